synch_down_counter: RTL

SYNCH_DOWN_COUNTER -- requirements
Module: synch_down_counter

---
 rtl/synch_down_counter.sv | 61 ++++++
 1 files changed

// File: rtl/synch_down_counter.sv
// Synchronous down counter with parallel load, zero flag and registered done/underflow pulses.
// Decrement uses per-bit toggle borrow logic; every flop is clocked by clk.
module synch_down_counter #(
    parameter int WIDTH = 4,
    parameter bit WRAP  = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] loadVal,
    output logic [WIDTH-1:0] outBus,
    output logic             zero,
    output logic             done,
    output logic             uflow
);

    logic [WIDTH-1:0] lower_zero;
    logic [WIDTH-1:0] toggle;
    logic [WIDTH-1:0] count_next;
    logic             at_zero;
    logic             at_one;
    logic             dec_req;
    logic             step;

    // lower_zero[i] is set when every bit below i is 0: the borrow chain for bit i.
    always_comb begin
        lower_zero[0] = 1'b1;
        for (int i = 1; i < WIDTH; i++) begin
            lower_zero[i] = lower_zero[i-1] & ~outBus[i-1];
        end
    end

    assign at_zero = lower_zero[WIDTH-1] & ~outBus[WIDTH-1];
    assign at_one  = (outBus == {{(WIDTH-1){1'b0}}, 1'b1});
    assign dec_req = en & ~load;

    // In saturating mode an enabled decrement at zero must not toggle anything.
    assign step       = dec_req & (WRAP | ~at_zero);
    assign toggle     = {WIDTH{step}} & lower_zero;
    assign count_next = outBus ^ toggle;

    always_ff @(posedge clk) begin
        if (rst) begin
            outBus <= {WIDTH{1'b1}};
            done   <= 1'b0;
            uflow  <= 1'b0;
        end else if (load) begin
            outBus <= loadVal;
            done   <= 1'b0;
            uflow  <= 1'b0;
        end else begin
            outBus <= count_next;
            done   <= dec_req & at_one;
            uflow  <= dec_req & at_zero;
        end
    end

    assign zero = (outBus == {WIDTH{1'b0}});

endmodule
